mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the Icache/Dcache requesters, the memory, and mem_arbiter.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int DATA_W = 64
);
    // Requester side
    logic [1:0]        proc2Imem_command;
    logic [XLEN-1:0]   proc2Imem_addr;
    logic [1:0]        proc2Dmem_command;
    logic [XLEN-1:0]   proc2Dmem_addr;
    logic [DATA_W-1:0] proc2Dmem_data;

    // Memory side
    logic [3:0]        Mem2proc_response;
    logic [DATA_W-1:0] Mem2proc_data;
    logic [3:0]        Mem2proc_tag;
    logic [1:0]        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [DATA_W-1:0] proc2mem_data;

    // Routed results and status
    logic [3:0]        Imem2proc_response;
    logic [3:0]        Dmem2proc_response;
    logic [3:0]        Imem2proc_tag;
    logic [3:0]        Dmem2proc_tag;
    logic [DATA_W-1:0] Imem2proc_data;
    logic [DATA_W-1:0] Dmem2proc_data;
    logic              orphan_err;
    logic [4:0]        outstanding_cnt;

    modport slave (
        input  proc2Imem_command, proc2Imem_addr,
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  Mem2proc_response, Mem2proc_data, Mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output Imem2proc_response, Dmem2proc_response,
        output Imem2proc_tag, Dmem2proc_tag,
        output Imem2proc_data, Dmem2proc_data,
        output orphan_err, outstanding_cnt
    );

    modport master (
        output proc2Imem_command, proc2Imem_addr,
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output Mem2proc_response, Mem2proc_data, Mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  Imem2proc_response, Dmem2proc_response,
        input  Imem2proc_tag, Dmem2proc_tag,
        input  Imem2proc_data, Dmem2proc_data,
        input  orphan_err, outstanding_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: Dcache-priority grant with Icache anti-starvation,
// plus a 16-entry tag ownership table that routes memory returns to the right cache.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
    localparam int SW     = (SW_RAW > 0) ? SW_RAW : 1;
    localparam logic [SW-1:0] LIMIT_V = SW'(STARVE_LIMIT);

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v >= LIMIT_V) ? LIMIT_V : v + SW'(1);
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    logic [15:0]   valid_tbl, valid_nxt;
    logic [15:0]   owner_tbl, owner_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          orphan_q, orphan_nxt;
    logic [4:0]    cnt_q, cnt_nxt;

    logic          i_req, d_req;
    logic          grant_i, grant_d;
    logic          alloc_en, alloc_owner;
    logic          ret_nz, ret_hit, ret_owner;
    logic          same_tag_turnover;
    logic [3:0]    resp, rtag;

    // Request decode and grant; a stray BUS_STORE on the Icache port counts as no request.
    always_comb begin
        resp    = bus.Mem2proc_response;
        rtag    = bus.Mem2proc_tag;
        i_req   = (bus.proc2Imem_command == BUS_LOAD);
        d_req   = (bus.proc2Dmem_command == BUS_LOAD) ||
                  (bus.proc2Dmem_command == BUS_STORE);
        grant_i = i_req && (!d_req || (starve_cnt >= LIMIT_V));
        grant_d = d_req && !grant_i;
    end

    // Return lookup against the table as it stands this cycle.
    always_comb begin
        ret_nz    = (rtag != 4'd0);
        ret_hit   = ret_nz && valid_tbl[rtag];
        ret_owner = owner_tbl[rtag];
    end

    // Stores are never tracked: only a granted load with a real tag allocates.
    always_comb begin
        alloc_en    = (resp != 4'd0) &&
                      (grant_i || (grant_d && (bus.proc2Dmem_command == BUS_LOAD)));
        alloc_owner = grant_d ? OWN_D : OWN_I;
        same_tag_turnover = ret_hit && (rtag == resp);
    end

    // Memory-facing command mux.
    always_comb begin
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (grant_i) begin
            bus.proc2mem_command = BUS_LOAD;
            bus.proc2mem_addr    = bus.proc2Imem_addr;
        end else if (grant_d) begin
            bus.proc2mem_command = bus.proc2Dmem_command;
            bus.proc2mem_addr    = bus.proc2Dmem_addr;
            if (bus.proc2Dmem_command == BUS_STORE) begin
                bus.proc2mem_data = bus.proc2Dmem_data;
            end
        end
    end

    // Requester-facing routing of acceptance tags, return tags and data.
    always_comb begin
        bus.Imem2proc_response = grant_i ? resp : 4'd0;
        bus.Dmem2proc_response = grant_d ? resp : 4'd0;
        bus.Imem2proc_tag      = (ret_hit && (ret_owner == OWN_I)) ? rtag : 4'd0;
        bus.Dmem2proc_tag      = (ret_hit && (ret_owner == OWN_D)) ? rtag : 4'd0;
        bus.Imem2proc_data     = bus.Mem2proc_data;
        bus.Dmem2proc_data     = bus.Mem2proc_data;
    end

    // Next table state: clear on return first so a same-cycle allocate of that tag wins.
    always_comb begin
        valid_nxt = valid_tbl;
        owner_nxt = owner_tbl;
        if (ret_nz) begin
            valid_nxt[rtag] = 1'b0;
        end
        if (alloc_en) begin
            valid_nxt[resp] = 1'b1;
            owner_nxt[resp] = alloc_owner;
        end
        cnt_nxt = popcount16(valid_nxt);
    end

    // Orphan detection: unknown return, or overwriting a live entry that is not turning over.
    always_comb begin
        orphan_nxt = orphan_q;
        if (ret_nz && !valid_tbl[rtag]) begin
            orphan_nxt = 1'b1;
        end
        if (alloc_en && valid_tbl[resp] && !same_tag_turnover) begin
            orphan_nxt = 1'b1;
        end
    end

    always_comb begin
        starve_nxt = (i_req && !grant_i) ? sat_inc(starve_cnt) : '0;
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_tbl  <= '0;
            owner_tbl  <= '0;
            starve_cnt <= '0;
            orphan_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_tbl  <= valid_nxt;
            owner_tbl  <= owner_nxt;
            starve_cnt <= starve_nxt;
            orphan_q   <= orphan_nxt;
            cnt_q      <= cnt_nxt;
        end
    end

    assign bus.orphan_err      = orphan_q;
    assign bus.outstanding_cnt = cnt_q;

    a_one_grant: assert property (@(posedge clock) disable iff (!reset)
        !(grant_i && grant_d));
    a_tag0_free: assert property (@(posedge clock) disable iff (!reset)
        !valid_tbl[0]);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, starvation run with a tag
// scoreboard, and hand-written overwrite / async-reset sequences.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam logic [1:0] BN = 2'd0;
    localparam logic [1:0] BL = 2'd1;
    localparam logic [1:0] BS = 2'd2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if #(.XLEN(XLEN), .DATA_W(64)) bus ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  icmd;
        logic [31:0] iaddr;
        logic [1:0]  dcmd;
        logic [31:0] daddr;
        logic [63:0] ddata;
        logic [3:0]  resp;
        logic [3:0]  rtag;
        logic [63:0] mdata;
        logic [1:0]  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic [3:0]  e_iresp;
        logic [3:0]  e_dresp;
        logic [3:0]  e_itag;
        logic [3:0]  e_dtag;
        logic [4:0]  e_cnt;
        logic        e_orph;
    } vec_t;

    typedef struct packed {
        logic [3:0] tag;
        logic       own_d;
    } sb_t;

    int checks = 0;
    int passed = 0;
    vec_t vt[15];
    sb_t  sbq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic [1:0] icmd, input logic [31:0] iaddr,
                         input logic [1:0] dcmd, input logic [31:0] daddr,
                         input logic [63:0] ddata, input logic [3:0] resp,
                         input logic [3:0] rtag, input logic [63:0] mdata);
        @(negedge clock);
        bus.proc2Imem_command = icmd;
        bus.proc2Imem_addr    = iaddr;
        bus.proc2Dmem_command = dcmd;
        bus.proc2Dmem_addr    = daddr;
        bus.proc2Dmem_data    = ddata;
        bus.Mem2proc_response = resp;
        bus.Mem2proc_tag      = rtag;
        bus.Mem2proc_data     = mdata;
        #2;
    endtask

    task automatic idle_drive(input logic [3:0] rtag);
        drive(BN, 32'h0, BN, 32'h0, 64'h0, 4'd0, rtag, 64'h0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clock);
        bus.proc2Imem_command = BN;
        bus.proc2Dmem_command = BN;
        bus.Mem2proc_response = 4'd0;
        bus.Mem2proc_tag      = 4'd0;
        reset = 1'b0;
        #1;
        check({name, "_cnt"},  64'(bus.outstanding_cnt), 64'd0);
        check({name, "_orph"}, 64'(bus.orphan_err), 64'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.proc2Imem_command = BN;
        bus.proc2Imem_addr    = '0;
        bus.proc2Dmem_command = BN;
        bus.proc2Dmem_addr    = '0;
        bus.proc2Dmem_data    = '0;
        bus.Mem2proc_response = '0;
        bus.Mem2proc_tag      = '0;
        bus.Mem2proc_data     = '0;

        vt[0]  = '{BL, 32'h100, BN, 32'h0, 64'h0, 4'd3, 4'd0, 64'h0,
                   BL, 32'h100, 64'h0, 4'd3, 4'd0, 4'd0, 4'd0, 5'd1, 1'b0};
        for (int i = 1; i <= 4; i++)
            vt[i] = '{BN, 32'h0, BN, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0,
                      BN, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd1, 1'b0};
        vt[5]  = '{BN, 32'h0, BN, 32'h0, 64'h0, 4'd0, 4'd3, 64'hAB,
                   BN, 32'h0, 64'h0, 4'd0, 4'd0, 4'd3, 4'd0, 5'd0, 1'b0};
        vt[6]  = '{BN, 32'h0, BS, 32'h200, 64'h1234, 4'd5, 4'd0, 64'h0,
                   BS, 32'h200, 64'h1234, 4'd0, 4'd5, 4'd0, 4'd0, 5'd0, 1'b0};
        for (int i = 7; i <= 10; i++)
            vt[i] = '{BL, 32'h400, BL, 32'h300, 64'h5555, 4'd0, 4'd0, 64'h0,
                      BL, 32'h300, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0};
        vt[11] = '{BL, 32'h400, BL, 32'h300, 64'h5555, 4'd2, 4'd0, 64'h0,
                   BL, 32'h400, 64'h0, 4'd2, 4'd0, 4'd0, 4'd0, 5'd1, 1'b0};
        vt[12] = '{BN, 32'h0, BL, 32'h500, 64'h77, 4'd2, 4'd2, 64'h0,
                   BL, 32'h500, 64'h0, 4'd0, 4'd2, 4'd2, 4'd0, 5'd1, 1'b0};
        vt[13] = '{BN, 32'h0, BN, 32'h0, 64'h0, 4'd0, 4'd2, 64'h99,
                   BN, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd2, 5'd0, 1'b0};
        vt[14] = '{BN, 32'h0, BN, 32'h0, 64'h0, 4'd0, 4'd5, 64'h0,
                   BN, 32'h0, 64'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b1};

        // Reset state
        #3;
        check("rst_cnt",  64'(bus.outstanding_cnt), 64'd0);
        check("rst_orph", 64'(bus.orphan_err), 64'd0);
        check("rst_cmd",  64'(bus.proc2mem_command), 64'(BN));
        check("rst_addr", 64'(bus.proc2mem_addr), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Vector table: Icache load/return, store orphan, zero response, same-tag turnover
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].icmd, vt[i].iaddr, vt[i].dcmd, vt[i].daddr,
                  vt[i].ddata, vt[i].resp, vt[i].rtag, vt[i].mdata);
            check($sformatf("v%0d_cmd", i),   64'(bus.proc2mem_command), 64'(vt[i].e_cmd));
            check($sformatf("v%0d_addr", i),  64'(bus.proc2mem_addr), 64'(vt[i].e_addr));
            check($sformatf("v%0d_data", i),  bus.proc2mem_data, vt[i].e_data);
            check($sformatf("v%0d_iresp", i), 64'(bus.Imem2proc_response), 64'(vt[i].e_iresp));
            check($sformatf("v%0d_dresp", i), 64'(bus.Dmem2proc_response), 64'(vt[i].e_dresp));
            check($sformatf("v%0d_itag", i),  64'(bus.Imem2proc_tag), 64'(vt[i].e_itag));
            check($sformatf("v%0d_dtag", i),  64'(bus.Dmem2proc_tag), 64'(vt[i].e_dtag));
            check($sformatf("v%0d_idata", i), bus.Imem2proc_data, vt[i].mdata);
            check($sformatf("v%0d_ddata", i), bus.Dmem2proc_data, vt[i].mdata);
            tick();
            check($sformatf("v%0d_cnt", i),   64'(bus.outstanding_cnt), 64'(vt[i].e_cnt));
            check($sformatf("v%0d_orph", i),  64'(bus.orphan_err), 64'(vt[i].e_orph));
        end

        // Starvation: both load every cycle; Icache must win every fifth cycle
        pulse_reset("rst1");
        begin
            logic [3:0] prev_resp;
            prev_resp = 4'd0;
            for (int k = 0; k < 20; k++) begin
                logic [3:0] r;
                logic       win_i;
                sb_t        e;
                r     = 4'(k % 15 + 1);
                win_i = ((k % 5) == 4);
                drive(BL, 32'h1000 + 32'(k), BL, 32'h2000 + 32'(k), 64'h0, r, prev_resp, 64'(k));
                check($sformatf("st%0d_addr", k), 64'(bus.proc2mem_addr),
                      64'(win_i ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k)));
                check($sformatf("st%0d_iresp", k), 64'(bus.Imem2proc_response), 64'(win_i ? r : 4'd0));
                check($sformatf("st%0d_dresp", k), 64'(bus.Dmem2proc_response), 64'(win_i ? 4'd0 : r));
                if (prev_resp != 4'd0) begin
                    e = sbq.pop_front();
                    check($sformatf("st%0d_itag", k), 64'(bus.Imem2proc_tag), 64'(e.own_d ? 4'd0 : e.tag));
                    check($sformatf("st%0d_dtag", k), 64'(bus.Dmem2proc_tag), 64'(e.own_d ? e.tag : 4'd0));
                end
                sbq.push_back('{tag: r, own_d: !win_i});
                tick();
                prev_resp = r;
            end
            idle_drive(prev_resp);
            begin
                sb_t e;
                e = sbq.pop_front();
                check("st_last_itag", 64'(bus.Imem2proc_tag), 64'(e.own_d ? 4'd0 : e.tag));
                check("st_last_dtag", 64'(bus.Dmem2proc_tag), 64'(e.own_d ? e.tag : 4'd0));
            end
            tick();
            check("st_sb_empty", 64'(sbq.size()), 64'd0);
            check("st_cnt",  64'(bus.outstanding_cnt), 64'd0);
            check("st_orph", 64'(bus.orphan_err), 64'd0);
        end

        // Overwrite of a live entry flags an orphan; the new owner keeps the tag
        pulse_reset("rst2");
        drive(BL, 32'h10, BN, 32'h0, 64'h0, 4'd7, 4'd0, 64'h0);
        tick();
        check("ow_cnt1",  64'(bus.outstanding_cnt), 64'd1);
        check("ow_orph1", 64'(bus.orphan_err), 64'd0);
        drive(BN, 32'h0, BL, 32'h20, 64'h0, 4'd7, 4'd0, 64'h0);
        check("ow_dresp", 64'(bus.Dmem2proc_response), 64'd7);
        tick();
        check("ow_cnt2",  64'(bus.outstanding_cnt), 64'd1);
        check("ow_orph2", 64'(bus.orphan_err), 64'd1);
        idle_drive(4'd7);
        check("ow_dtag", 64'(bus.Dmem2proc_tag), 64'd7);
        check("ow_itag", 64'(bus.Imem2proc_tag), 64'd0);
        tick();
        check("ow_cnt3", 64'(bus.outstanding_cnt), 64'd0);

        // Reset with three loads outstanding drops all ownership
        pulse_reset("rst3");
        drive(BL, 32'h30, BN, 32'h0, 64'h0, 4'd1, 4'd0, 64'h0);
        tick();
        drive(BN, 32'h0, BL, 32'h40, 64'h0, 4'd2, 4'd0, 64'h0);
        tick();
        drive(BL, 32'h50, BN, 32'h0, 64'h0, 4'd3, 4'd0, 64'h0);
        tick();
        check("mr_cnt3", 64'(bus.outstanding_cnt), 64'd3);
        pulse_reset("mr_rst");
        idle_drive(4'd1);
        check("mr_itag", 64'(bus.Imem2proc_tag), 64'd0);
        check("mr_dtag", 64'(bus.Dmem2proc_tag), 64'd0);
        tick();
        check("mr_orph", 64'(bus.orphan_err), 64'd1);
        check("mr_cnt0", 64'(bus.outstanding_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
